// File: rtl/argmax_classifier.sv
// Streaming argmax: reduces a frame of NUM_CLASSES scores (LANES per beat) to the
// index/value of the largest score. Ties go to the lowest index; overlong frames are flagged.

module argmax_gt #(
  parameter int DATA_W = 16,
  parameter int SIGNED = 1
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_gt
);
  assign o_gt = (SIGNED != 0) ? ($signed(i_a) > $signed(i_b)) : (i_a > i_b);
endmodule

module argmax_classifier #(
  parameter int DATA_W      = 16,
  parameter int LANES       = 1,
  parameter int NUM_CLASSES = 1000,
  parameter int IDX_W       = 10,
  parameter int SIGNED      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_index,
  output logic [DATA_W-1:0]       out_max,
  output logic                    out_len_err
);

  typedef enum logic {ACCUM, HOLD} state_t;

  // One extra count bit so the element counter can reach NUM_CLASSES without wrapping.
  localparam logic [IDX_W:0] NUM_C   = (IDX_W+1)'(NUM_CLASSES);
  localparam logic [IDX_W:0] LANES_C = (IDX_W+1)'(LANES);

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_max;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W:0]      r_cnt;
  logic                r_first;
  logic                r_len_err;

  logic                w_accept, w_close, w_ovr, w_take, w_run_gt, w_len_err_nxt;
  logic [DATA_W-1:0]   w_cand_val;
  logic [IDX_W-1:0]    w_cand_lane, w_cand_idx;
  logic [IDX_W:0]      w_cnt_inc;

  // Lane reduction chain: a later lane only wins on strictly greater, so ties keep the lower lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_W-1:0] w_val;
    logic [IDX_W-1:0]  w_idx;
    if (k == 0) begin : g_base
      assign w_val = in_data[0 +: DATA_W];
      assign w_idx = '0;
    end else begin : g_step
      logic w_gt;
      argmax_gt #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_gt (
        .i_a (in_data[k*DATA_W +: DATA_W]),
        .i_b (g_lane[k-1].w_val),
        .o_gt(w_gt)
      );
      assign w_val = w_gt ? in_data[k*DATA_W +: DATA_W] : g_lane[k-1].w_val;
      assign w_idx = w_gt ? IDX_W'(k) : g_lane[k-1].w_idx;
    end
  end

  assign w_cand_val  = g_lane[LANES-1].w_val;
  assign w_cand_lane = g_lane[LANES-1].w_idx;

  argmax_gt #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_run_gt (
    .i_a (w_cand_val),
    .i_b (r_max),
    .o_gt(w_run_gt)
  );

  assign in_ready   = (r_state == ACCUM) && !rst;
  assign out_valid  = (r_state == HOLD);
  assign out_index  = r_idx;
  assign out_max    = r_max;
  assign out_len_err = r_len_err;

  assign w_accept   = in_valid && in_ready;
  assign w_close    = w_accept && in_last;
  assign w_ovr      = (r_cnt >= NUM_C);
  assign w_cnt_inc  = r_cnt + LANES_C;
  assign w_cand_idx = r_cnt[IDX_W-1:0] + w_cand_lane;
  assign w_take     = !w_ovr && (r_first || w_run_gt);
  // Error from an earlier beat only counts inside the current frame.
  assign w_len_err_nxt = (!r_first && r_len_err) || w_ovr ||
                         (w_close && !w_ovr && (w_cnt_inc != NUM_C));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: if (w_close)   w_state_nxt = HOLD;
      HOLD:  if (out_ready) w_state_nxt = ACCUM;
      default:              w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
      r_len_err <= 1'b0;
    end else if (w_accept) begin
      if (w_take) begin
        r_max <= w_cand_val;
        r_idx <= w_cand_idx;
      end
      r_len_err <= w_len_err_nxt;
      if (w_close) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else begin
        if (!w_ovr) r_cnt <= w_cnt_inc;
        r_first <= 1'b0;
      end
    end
  end

endmodule
